operand_forward_stage: RTL and testbench
========================================

# operand_forward_stage

Parametrised ID/EX operand stage for the MIPS pipeline. It resolves ALU operands A and B and the store-data operand from the register file or from any of NFWD in-flight writer ports, with nearest-stage priority. It detects not-yet-ready producers (load-use and similar) and stalls ID with a valid/ready handshake. Resolved operands are registered into EX, together with source-select tags and a saturating hazard-cycle counter.

## Interface
- NBITS, 32, datapath width
- REGADDR, 5, register address width
- NFWD, 3, number of forwarding ports; port 0 is the youngest (highest priority)
- SELW, 2, width of source tags; must satisfy 2^SELW ≥ NFWD+1
- CNTW, 16, hazard counter width

- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_id_valid  in  1  ID holds an instruction
- o_id_ready  out  1  stage accepts the ID instruction this cycle
- i_rs, i_rt  in  REGADDR each  source register numbers
- i_use_rs, i_use_rt  in  1 each  instruction actually reads rs / rt
- i_rs_data, i_rt_data  in  NBITS each  register-file read data
- i_imm  in  NBITS  extended immediate
- i_alu_src  in  1  1: operand B is i_imm; 0: operand B is forwarded rt
- i_fwd_valid  in  NFWD  port k holds a register-writing instruction
- i_fwd_addr  in  NFWD*REGADDR  destination of port k, packed in slice [k*REGADDR +: REGADDR]
- i_fwd_ready  in  NFWD  port k data is final (0 for a load not yet at WB)
- i_fwd_data  in  NFWD*NBITS  port k result, packed in slice [k*NBITS +: NBITS]
- i_ex_ready  in  1  EX consumes o_ex_* this cycle
- i_flush  in  1  kill the registered EX entry and the ID candidate
- o_ex_valid  out  1  registered operands valid
- o_op_a, o_op_b, o_store_data  out  NBITS each  registered operands
- o_src_a, o_src_b  out  SELW each  source tag: 0 is the register file, k+1 is port k
- o_state  out  2  0 RUN, 1 HAZARD, 2 BLOCKED
- o_haz_cycles  out  CNTW  saturating count of hazard-stall cycles

## Operation
- Port match for port k and register r: i_fwd_valid[k] && addr_k==r && r!=0. Register 0 is never forwarded and always reads as i_*_data.
- Resolution per operand: take the lowest-index matching port; with no match, use the register file.
- Operand B and store data both use rt resolution. Store data is always the resolved rt, independent of i_alu_src. op_b = i_alu_src ? i_imm : resolved rt.
- Hazard: i_use_rs and the winning rs port has ready=0, or i_use_rt and the winning rt port has ready=0. A lower-priority ready match never overrides a higher-priority not-ready match.
- o_id_ready = !hazard && !i_flush && (!o_ex_valid || i_ex_ready).
- Load: i_id_valid && o_id_ready. On load, all o_ex_* outputs register, o_ex_valid=1, and the src tags record the winning source. o_src_b is 0 when i_alu_src=1.
- Otherwise, if i_ex_ready or i_flush, then o_ex_valid=0 (bubble). Data registers hold their values.
- i_flush wins over load and over hold. Next cycle o_ex_valid=0.
- Otherwise the stage holds all outputs, with no change while blocked.
- State, registered from this cycle's conditions:
  - HAZARD when i_id_valid && hazard && !i_flush.
  - Else BLOCKED when o_ex_valid && !i_ex_ready && !i_flush.
  - Else RUN.
- o_haz_cycles increments on every cycle with i_id_valid && hazard && !i_flush. It saturates at 2^CNTW-1 and only reset clears it.

## Timing
- Reset values: o_ex_valid=0; o_op_a, o_op_b and o_store_data=0; src tags 0; o_state=RUN; o_haz_cycles=0. o_id_ready follows combinationally (1 after reset when no hazard).
- Latency is 1 cycle from load edge to o_ex_*.
- The resolution and hazard paths are combinational from the current i_fwd_* values. No state is carried across cycles except the output register and the counter.
- A hazard lasts while the producer's ready=0. The cycle the producer's ready rises (or the producer leaves the ports), the load happens on that edge if EX allows.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first load is possible on the first edge after deassertion.

## Test plan
- Priority: rs=5, ports 0/1/2 all target r5 with ready=1 and data 0xA/0xB/0xC, load → o_op_a=0xA, o_src_a=1. Drop port 0 valid → 0xB, o_src_a=2.
- Register zero: rt=0, port 0 targets r0 with data 0xDEAD, i_rt_data=0 → o_op_b=0, o_src_b=0.
- Load-use: port 0 targets r7 with ready=0, i_use_rt=1, rt=7 → o_id_ready=0, state HAZARD, counter +1 per cycle. Raise ready with data 0x55 → load; o_store_data=0x55 next cycle.
- Shadowing: port 0 (r3, ready=0) and port 1 (r3, ready=1) → stall persists. With i_use_rs=0 and only rs=3 → no stall.
- Backpressure and flush: o_ex_valid=1 and i_ex_ready=0 for 3 cycles → outputs stable and state BLOCKED. Assert i_flush with i_id_valid=1 → o_ex_valid=0 next cycle and no load.
- Counter saturation (CNTW=2): hazard held 6 cycles → o_haz_cycles=3. Async reset mid-stall → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/operand_forward_stage.sv
// ID/EX operand stage: resolves A, B and store-data from the register file or in-flight
// writer ports (youngest first), stalls ID on not-ready producers, and registers into EX.
module operand_forward_stage #(
    parameter int NBITS   = 32,
    parameter int REGADDR = 5,
    parameter int NFWD    = 3,
    parameter int SELW    = 2,
    parameter int CNTW    = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_id_valid,
    output logic                     o_id_ready,
    input  logic [REGADDR-1:0]       i_rs,
    input  logic [REGADDR-1:0]       i_rt,
    input  logic                     i_use_rs,
    input  logic                     i_use_rt,
    input  logic [NBITS-1:0]         i_rs_data,
    input  logic [NBITS-1:0]         i_rt_data,
    input  logic [NBITS-1:0]         i_imm,
    input  logic                     i_alu_src,
    input  logic [NFWD-1:0]          i_fwd_valid,
    input  logic [NFWD*REGADDR-1:0]  i_fwd_addr,
    input  logic [NFWD-1:0]          i_fwd_ready,
    input  logic [NFWD*NBITS-1:0]    i_fwd_data,
    input  logic                     i_ex_ready,
    input  logic                     i_flush,
    output logic                     o_ex_valid,
    output logic [NBITS-1:0]         o_op_a,
    output logic [NBITS-1:0]         o_op_b,
    output logic [NBITS-1:0]         o_store_data,
    output logic [SELW-1:0]          o_src_a,
    output logic [SELW-1:0]          o_src_b,
    output logic [1:0]               o_state,
    output logic [CNTW-1:0]          o_haz_cycles
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HAZARD  = 2'd1;
    localparam logic [1:0] ST_BLOCKED = 2'd2;

    typedef struct packed {
        logic              rdy;
        logic [SELW-1:0]   sel;
        logic [NBITS-1:0]  data;
    } res_t;

    // Scanning from the oldest port down lets the youngest match overwrite older ones,
    // so a not-ready young producer shadows any ready older copy of the same register.
    function automatic res_t resolve(input logic [REGADDR-1:0] r,
                                     input logic [NBITS-1:0]   rf_data);
        res_t res;
        res.rdy  = 1'b1;
        res.sel  = '0;
        res.data = rf_data;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (i_fwd_valid[k] && (i_fwd_addr[k*REGADDR +: REGADDR] == r) && (r != '0)) begin
                res.rdy  = i_fwd_ready[k];
                res.sel  = SELW'(k + 1);
                res.data = i_fwd_data[k*NBITS +: NBITS];
            end
        end
        return res;
    endfunction

    res_t rs_res;
    res_t rt_res;
    logic hazard;
    logic load;
    logic haz_cycle;

    always_comb begin
        rs_res = resolve(i_rs, i_rs_data);
        rt_res = resolve(i_rt, i_rt_data);
    end

    assign hazard     = (i_use_rs && !rs_res.rdy) || (i_use_rt && !rt_res.rdy);
    assign o_id_ready = !hazard && !i_flush && (!o_ex_valid || i_ex_ready);
    assign load       = i_id_valid && o_id_ready;
    assign haz_cycle  = i_id_valid && hazard && !i_flush;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_ex_valid   <= 1'b0;
            o_op_a       <= '0;
            o_op_b       <= '0;
            o_store_data <= '0;
            o_src_a      <= '0;
            o_src_b      <= '0;
        end else if (i_flush) begin
            o_ex_valid <= 1'b0;
        end else if (load) begin
            o_ex_valid   <= 1'b1;
            o_op_a       <= rs_res.data;
            o_op_b       <= i_alu_src ? i_imm : rt_res.data;
            o_store_data <= rt_res.data;
            o_src_a      <= rs_res.sel;
            o_src_b      <= i_alu_src ? '0 : rt_res.sel;
        end else if (i_ex_ready) begin
            o_ex_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_state <= ST_RUN;
        end else if (haz_cycle) begin
            o_state <= ST_HAZARD;
        end else if (o_ex_valid && !i_ex_ready && !i_flush) begin
            o_state <= ST_BLOCKED;
        end else begin
            o_state <= ST_RUN;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_haz_cycles <= '0;
        end else if (haz_cycle && (o_haz_cycles != '1)) begin
            o_haz_cycles <= o_haz_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_operand_forward_stage.sv
// Directed bench for operand_forward_stage; loads are checked through an expected-result queue,
// a second instance with a 2-bit counter covers saturation.
module tb_operand_forward_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  rs, rt;
    logic        use_rs, use_rt;
    logic [31:0] rs_data, rt_data, imm;
    logic        alu_src;
    logic [2:0]  fwd_valid, fwd_ready;
    logic [14:0] fwd_addr;
    logic [95:0] fwd_data;
    logic        ex_ready, flush;

    logic        id_ready, ex_valid;
    logic [31:0] op_a, op_b, store_data;
    logic [1:0]  src_a, src_b, state;
    logic [15:0] haz_cycles;

    logic        id_ready2, ex_valid2;
    logic [31:0] op_a2, op_b2, store_data2;
    logic [1:0]  src_a2, src_b2, state2;
    logic [1:0]  haz_cycles2;

    typedef struct {
        logic [31:0] a, b, sd;
        logic [1:0]  sa, sb;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    operand_forward_stage dut (
        .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid), .o_id_ready(id_ready),
        .i_rs(rs), .i_rt(rt), .i_use_rs(use_rs), .i_use_rt(use_rt),
        .i_rs_data(rs_data), .i_rt_data(rt_data), .i_imm(imm), .i_alu_src(alu_src),
        .i_fwd_valid(fwd_valid), .i_fwd_addr(fwd_addr), .i_fwd_ready(fwd_ready),
        .i_fwd_data(fwd_data), .i_ex_ready(ex_ready), .i_flush(flush),
        .o_ex_valid(ex_valid), .o_op_a(op_a), .o_op_b(op_b), .o_store_data(store_data),
        .o_src_a(src_a), .o_src_b(src_b), .o_state(state), .o_haz_cycles(haz_cycles)
    );

    operand_forward_stage #(.CNTW(2)) dut_sat (
        .i_clk(clk), .i_reset(rst), .i_id_valid(id_valid), .o_id_ready(id_ready2),
        .i_rs(rs), .i_rt(rt), .i_use_rs(use_rs), .i_use_rt(use_rt),
        .i_rs_data(rs_data), .i_rt_data(rt_data), .i_imm(imm), .i_alu_src(alu_src),
        .i_fwd_valid(fwd_valid), .i_fwd_addr(fwd_addr), .i_fwd_ready(fwd_ready),
        .i_fwd_data(fwd_data), .i_ex_ready(ex_ready), .i_flush(flush),
        .o_ex_valid(ex_valid2), .o_op_a(op_a2), .o_op_b(op_b2), .o_store_data(store_data2),
        .o_src_a(src_a2), .o_src_b(src_b2), .o_state(state2), .o_haz_cycles(haz_cycles2)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic set_port(input int k, input logic v, input logic [4:0] a,
                            input logic r, input logic [31:0] d);
        fwd_valid[k]         = v;
        fwd_addr[k*5 +: 5]   = a;
        fwd_ready[k]         = r;
        fwd_data[k*32 +: 32] = d;
    endtask

    task automatic apply_stimulus(input logic v, input logic [4:0] s, input logic us,
                                  input logic [31:0] sdat, input logic [4:0] t, input logic ut,
                                  input logic [31:0] tdat, input logic asrc, input logic [31:0] im);
        id_valid = v;
        rs = s; use_rs = us; rs_data = sdat;
        rt = t; use_rt = ut; rt_data = tdat;
        alu_src = asrc; imm = im;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                            input logic [1:0] sa, input logic [1:0] sb);
        exp_t e;
        e.a = a; e.b = b; e.sd = sd; e.sa = sa; e.sb = sb;
        exp_q.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("[TB] FAIL scoreboard_underflow: observed=load expected=no_entry");
        end else begin
            e = exp_q.pop_front();
            check("ex_valid", 64'(ex_valid), 64'd1);
            check("op_a", 64'(op_a), 64'(e.a));
            check("op_b", 64'(op_b), 64'(e.b));
            check("store_data", 64'(store_data), 64'(e.sd));
            check("src_a", 64'(src_a), 64'(e.sa));
            check("src_b", 64'(src_b), 64'(e.sb));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ex_valid"}, 64'(ex_valid), 64'd0);
        check({tag, "_op_a"}, 64'(op_a), 64'd0);
        check({tag, "_op_b"}, 64'(op_b), 64'd0);
        check({tag, "_store"}, 64'(store_data), 64'd0);
        check({tag, "_src_a"}, 64'(src_a), 64'd0);
        check({tag, "_src_b"}, 64'(src_b), 64'd0);
        check({tag, "_state"}, 64'(state), 64'd0);
        check({tag, "_haz"}, 64'(haz_cycles), 64'd0);
        check({tag, "_haz_sat"}, 64'(haz_cycles2), 64'd0);
        check({tag, "_ex_valid_sat"}, 64'(ex_valid2), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        fwd_valid = '0; fwd_addr = '0; fwd_ready = '0; fwd_data = '0;
        ex_ready = 1'b1; flush = 1'b0;
        apply_stimulus(1'b0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_id_ready", 64'(id_ready), 64'd1);

        // Priority: all three ports write r5, youngest wins
        @(negedge clk);
        set_port(0, 1'b1, 5'd5, 1'b1, 32'hA);
        set_port(1, 1'b1, 5'd5, 1'b1, 32'hB);
        set_port(2, 1'b1, 5'd5, 1'b1, 32'hC);
        apply_stimulus(1'b1, 5'd5, 1'b1, 32'h99, 5'd1, 1'b1, 32'h11, 1'b0, 32'h0);
        push_exp(32'hA, 32'h11, 32'h11, 2'd1, 2'd0);
        #1;
        check("prio_id_ready", 64'(id_ready), 64'd1);
        next_cycle();
        check_output();
        check("prio_state", 64'(state), 64'd0);

        set_port(0, 1'b0, 5'd5, 1'b1, 32'hA);
        push_exp(32'hB, 32'h11, 32'h11, 2'd2, 2'd0);
        next_cycle();
        check_output();

        // Register zero is never forwarded
        set_port(0, 1'b1, 5'd0, 1'b1, 32'hDEAD);
        set_port(1, 1'b0, 5'd0, 1'b0, 32'h0);
        set_port(2, 1'b0, 5'd0, 1'b0, 32'h0);
        apply_stimulus(1'b1, 5'd2, 1'b1, 32'h22, 5'd0, 1'b1, 32'h0, 1'b0, 32'h0);
        push_exp(32'h22, 32'h0, 32'h0, 2'd0, 2'd0);
        next_cycle();
        check_output();

        // Immediate operand: store data still carries forwarded rt
        set_port(0, 1'b0, 5'd0, 1'b0, 32'h0);
        set_port(1, 1'b1, 5'd4, 1'b1, 32'h44);
        apply_stimulus(1'b1, 5'd2, 1'b1, 32'h22, 5'd4, 1'b1, 32'h4, 1'b1, 32'h1234);
        push_exp(32'h22, 32'h1234, 32'h44, 2'd0, 2'd0);
        next_cycle();
        check_output();

        // Load-use on rt
        set_port(1, 1'b0, 5'd0, 1'b0, 32'h0);
        set_port(0, 1'b1, 5'd7, 1'b0, 32'h0);
        apply_stimulus(1'b1, 5'd0, 1'b0, 32'h0, 5'd7, 1'b1, 32'h70, 1'b0, 32'h0);
        #1;
        check("lu_id_ready", 64'(id_ready), 64'd0);
        next_cycle();
        check("lu_state1", 64'(state), 64'd1);
        check("lu_haz1", 64'(haz_cycles), 64'd1);
        check("lu_bubble", 64'(ex_valid), 64'd0);
        next_cycle();
        check("lu_haz2", 64'(haz_cycles), 64'd2);
        set_port(0, 1'b1, 5'd7, 1'b1, 32'h55);
        #1;
        check("lu_release_ready", 64'(id_ready), 64'd1);
        push_exp(32'h0, 32'h55, 32'h55, 2'd0, 2'd1);
        next_cycle();
        check_output();
        check("lu_state_run", 64'(state), 64'd0);
        check("lu_haz_hold", 64'(haz_cycles), 64'd2);

        // Shadowing: young not-ready copy beats older ready copy
        set_port(0, 1'b1, 5'd3, 1'b0, 32'h30);
        set_port(1, 1'b1, 5'd3, 1'b1, 32'h33);
        apply_stimulus(1'b1, 5'd3, 1'b1, 32'h3, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        check("shadow_id_ready", 64'(id_ready), 64'd0);
        next_cycle();
        check("shadow_state", 64'(state), 64'd1);
        check("shadow_haz", 64'(haz_cycles), 64'd3);
        use_rs = 1'b0;
        #1;
        check("nouse_id_ready", 64'(id_ready), 64'd1);
        push_exp(32'h30, 32'h0, 32'h0, 2'd1, 2'd0);
        next_cycle();
        check_output();

        // Backpressure then flush
        set_port(0, 1'b0, 5'd0, 1'b0, 32'h0);
        set_port(1, 1'b0, 5'd0, 1'b0, 32'h0);
        apply_stimulus(1'b1, 5'd1, 1'b1, 32'h77, 5'd2, 1'b1, 32'h78, 1'b0, 32'h0);
        ex_ready = 1'b0;
        #1;
        check("bp_id_ready", 64'(id_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check("bp_valid", 64'(ex_valid), 64'd1);
            check("bp_op_a", 64'(op_a), 64'h30);
            check("bp_src_a", 64'(src_a), 64'd1);
            check("bp_state", 64'(state), 64'd2);
        end
        flush = 1'b1;
        #1;
        check("flush_id_ready", 64'(id_ready), 64'd0);
        next_cycle();
        check("flush_valid", 64'(ex_valid), 64'd0);
        check("flush_no_load", 64'(op_a), 64'h30);
        check("flush_state", 64'(state), 64'd0);
        flush = 1'b0;
        ex_ready = 1'b1;

        // Long hazard: wide counter keeps counting, 2-bit one stays saturated
        set_port(0, 1'b1, 5'd9, 1'b0, 32'h9);
        apply_stimulus(1'b1, 5'd9, 1'b1, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            check("sat_haz_wide", 64'(haz_cycles), 64'(4 + i));
            check("sat_haz_narrow", 64'(haz_cycles2), 64'd3);
            check("sat_state", 64'(state), 64'd1);
        end
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midreset");

        @(negedge clk);
        rst = 1'b0;
        set_port(0, 1'b0, 5'd0, 1'b0, 32'h0);
        apply_stimulus(1'b1, 5'd1, 1'b1, 32'h5A, 5'd2, 1'b1, 32'h6B, 1'b0, 32'h0);
        push_exp(32'h5A, 32'h6B, 32'h6B, 2'd0, 2'd0);
        next_cycle();
        check_output();
        check("post_reset_haz", 64'(haz_cycles), 64'd0);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
